// File: rtl/irq_pending_ctrl.sv
// Interrupt pending/acknowledge controller: latches 8 request lines, feeds an external
// 8-to-3 priority encoder and offers the encoded vector over valid/ready.
// Define IRQ_EDGE_DETECT_EN for edge-triggered requests; otherwise requests are level-sensitive.
module irq_pending_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq,
  input  logic [7:0] mask,
  input  logic       enable,
  output logic [7:0] enc_i,
  output logic       enc_ei,
  input  logic [2:0] enc_y,
  input  logic       enc_gs,
  input  logic       enc_eo,
  output logic       vec_valid,
  output logic [2:0] vec,
  input  logic       vec_ready,
  output logic       idle_empty,
  output logic [7:0] missed_cnt
);

  localparam int NUM_LANES = 8;

  typedef enum logic [1:0] {IDLE, OFFER, GAP} state_t;

  state_t               state;
  logic [NUM_LANES-1:0] irq_q;
  logic [NUM_LANES-1:0] pending;
  logic [NUM_LANES-1:0] set;
  logic [NUM_LANES-1:0] clr;
  logic                 hs;

  assign hs = (state == OFFER) & vec_valid & vec_ready;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic q_r;
    logic p_r;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q_r <= 1'b0;
        p_r <= 1'b0;
      end else begin
        q_r <= irq[g];
        // set wins over a same-cycle clear, so a fresh request is never lost
        p_r <= (p_r & ~clr[g]) | set[g];
      end
    end

    assign irq_q[g]   = q_r;
    assign pending[g] = p_r;
    assign clr[g]     = hs & (vec == 3'(g));
`ifdef IRQ_EDGE_DETECT_EN
    assign set[g]     = irq[g] & ~q_r;
`else
    assign set[g]     = q_r;
`endif
  end

  assign enc_i  = pending & ~mask;
  assign enc_ei = enable & (state == IDLE);

`ifdef IRQ_EDGE_DETECT_EN
  logic any_miss;
  assign any_miss = |(set & pending & ~clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      missed_cnt <= 8'd0;
    else if (any_miss && (missed_cnt != 8'hFF))
      missed_cnt <= missed_cnt + 8'd1;
  end
`else
  assign missed_cnt = 8'd0;
`endif

  // GAP gives the cleared pending bit a cycle to leave the encoder before the next capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= 3'd0;
      vec_valid  <= 1'b0;
      idle_empty <= 1'b0;
    end else begin
      idle_empty <= (state == IDLE) & enc_eo;
      case (state)
        IDLE: begin
          if (enc_gs) begin
            vec       <= enc_y;
            vec_valid <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (vec_ready) begin
            vec_valid <= 1'b0;
            state     <= GAP;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl: directed vector table, hand sequences for stall/saturation/reset,
// and a randomized run against a behavioural model. Includes a model of the priority encoder.
module tb_irq_pending_ctrl;

`ifdef IRQ_EDGE_DETECT_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] irq = 8'h00;
  logic [7:0] mask = 8'h00;
  logic       enable = 1'b1;
  logic [7:0] enc_i;
  logic       enc_ei;
  logic [2:0] enc_y;
  logic       enc_gs;
  logic       enc_eo;
  logic       vec_valid;
  logic [2:0] vec;
  logic       vec_ready = 1'b1;
  logic       idle_empty;
  logic [7:0] missed_cnt;

  always #5 clk = ~clk;

  irq_pending_ctrl dut (
    .clk(clk), .rst(rst), .irq(irq), .mask(mask), .enable(enable),
    .enc_i(enc_i), .enc_ei(enc_ei), .enc_y(enc_y), .enc_gs(enc_gs), .enc_eo(enc_eo),
    .vec_valid(vec_valid), .vec(vec), .vec_ready(vec_ready),
    .idle_empty(idle_empty), .missed_cnt(missed_cnt)
  );

  // adjacent priority encoder: highest set input wins, gated by EI
  always_comb begin
    enc_y  = 3'd0;
    enc_gs = 1'b0;
    enc_eo = 1'b0;
    if (enc_ei) begin
      if (enc_i == 8'h00) enc_eo = 1'b1;
      else begin
        enc_gs = 1'b1;
        for (int i = 0; i < 8; i++) if (enc_i[i]) enc_y = 3'(i);
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic [7:0] i, input logic [7:0] m, input logic en, input logic rd);
    irq = i; mask = m; enable = en; vec_ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #3 rst = 1'b1;
    irq = 8'h00; mask = 8'h00; enable = 1'b1; vec_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0] irq;
    logic [7:0] mask;
    logic       en;
    logic       rdy;
    logic       ev;
    logic [2:0] evec;
    logic [7:0] eenc;
  } row_t;

  row_t tbl[$];

  function automatic void add(input logic [7:0] i, input logic [7:0] m, input logic en,
                              input logic rd, input logic ev, input logic [2:0] evec,
                              input logic [7:0] eenc);
    row_t r;
    r.irq = i; r.mask = m; r.en = en; r.rdy = rd; r.ev = ev; r.evec = evec; r.eenc = eenc;
    tbl.push_back(r);
  endfunction

  // level requests land in pending one cycle later than edge requests
  function automatic void pulse(input logic [7:0] i, input logic [7:0] m, input logic en,
                                input logic rd, input logic [7:0] prev_enc,
                                input logic [7:0] new_enc, input logic ev, input logic [2:0] evec);
    if (EDGE) add(i, m, en, rd, ev, evec, new_enc);
    else begin
      add(i, m, en, rd, ev, evec, prev_enc);
      add(8'h00, m, en, rd, ev, evec, new_enc);
    end
  endfunction

  // behavioural reference model
  logic [7:0] m_pend, m_prev, m_miss;
  logic [2:0] m_vec;
  logic       m_valid, m_ie;
  int         m_phase;

  function automatic void model_reset();
    m_pend = 8'h00; m_prev = 8'h00; m_miss = 8'h00;
    m_vec = 3'd0; m_valid = 1'b0; m_ie = 1'b0; m_phase = 0;
  endfunction

  function automatic void model_step(input logic [7:0] i, input logic [7:0] m,
                                     input logic en, input logic rd);
    logic [7:0] setv, clrv;
    int top;
    setv = EDGE ? (i & ~m_prev) : m_prev;
    clrv = (m_valid && rd) ? (8'h01 << m_vec) : 8'h00;
    top = -1;
    for (int k = 0; k < 8; k++) if (m_pend[k] && !m[k]) top = k;
    m_ie = (m_phase == 0) && en && (top < 0);
    if (EDGE && ((setv & m_pend & ~clrv) != 8'h00) && m_miss != 8'hFF) m_miss = m_miss + 8'd1;
    case (m_phase)
      0: if (en && top >= 0) begin m_vec = 3'(top); m_valid = 1'b1; m_phase = 1; end
      1: if (rd) begin m_valid = 1'b0; m_phase = 2; end
      default: m_phase = 0;
    endcase
    m_pend = (m_pend & ~clrv) | setv;
    m_prev = i;
  endfunction

  initial begin
    int k;
    // ---- reset state ----
    do_reset();
    chk("rst_valid", 8'(vec_valid), 8'h00);
    chk("rst_vec", 8'(vec), 8'h00);
    chk("rst_enc_i", enc_i, 8'h00);
    chk("rst_missed", missed_cnt, 8'h00);
    chk("rst_idle_empty", 8'(idle_empty), 8'h00);
    cyc(8'h00, 8'h00, 1'b1, 1'b1);
    cyc(8'h00, 8'h00, 1'b1, 1'b1);
    chk("idle_empty_set", 8'(idle_empty), 8'h01);
    chk("idle_valid", 8'(vec_valid), 8'h00);
    chk("idle_enc_i", enc_i, 8'h00);

    // ---- table: 0x24 pulse ----
    pulse(8'h24, 8'h00, 1'b1, 1'b1, 8'h00, 8'h24, 1'b0, 3'd0);
    add(8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 3'd5, 8'h24);
    add(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h04);
    add(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h04);
    add(8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 3'd2, 8'h04);
    add(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00);
    add(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00);
    // masked line 7 waits until unmasked
    pulse(8'h82, 8'h80, 1'b1, 1'b1, 8'h00, 8'h02, 1'b0, 3'd0);
    add(8'h00, 8'h80, 1'b1, 1'b1, 1'b1, 3'd1, 8'h02);
    add(8'h00, 8'h80, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00);
    add(8'h00, 8'h80, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00);
    add(8'h00, 8'h80, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00);
    add(8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 3'd7, 8'h80);
    add(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00);
    add(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00);
    // stalled offer of 3 with enable toggling and irq[6] arriving
    pulse(8'h08, 8'h00, 1'b1, 1'b0, 8'h00, 8'h08, 1'b0, 3'd0);
    add(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 8'h08);
    add(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08);
    add(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 8'h08);
    pulse(8'h40, 8'h00, 1'b0, 1'b0, 8'h08, 8'h48, 1'b1, 3'd3);
    for (int j = 0; j < 6; j++) add(8'h00, 8'h00, 1'(j % 2), 1'b0, 1'b1, 3'd3, 8'h48);
    add(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h40);
    add(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h40);
    add(8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 3'd6, 8'h40);
    add(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00);
    add(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00);

    foreach (tbl[r]) begin
      cyc(tbl[r].irq, tbl[r].mask, tbl[r].en, tbl[r].rdy);
      chk($sformatf("tbl%0d_valid", r), 8'(vec_valid), 8'(tbl[r].ev));
      if (tbl[r].ev) chk($sformatf("tbl%0d_vec", r), 8'(vec), 8'(tbl[r].evec));
      chk($sformatf("tbl%0d_enc_i", r), enc_i, tbl[r].eenc);
    end

    // ---- missed requests on a stalled line, then saturation ----
    cyc(8'h10, 8'h00, 1'b1, 1'b0);
    k = 0;
    while (!vec_valid && k < 6) begin cyc(8'h00, 8'h00, 1'b1, 1'b0); k++; end
    chk("miss_offer_valid", 8'(vec_valid), 8'h01);
    chk("miss_offer_vec", 8'(vec), 8'h04);
    for (int j = 0; j < 3; j++) begin
      cyc(8'h10, 8'h00, 1'b1, 1'b0);
      cyc(8'h00, 8'h00, 1'b1, 1'b0);
    end
    chk("missed_3", missed_cnt, EDGE ? 8'd3 : 8'd0);
    for (int j = 0; j < 260; j++) begin
      cyc(8'h10, 8'h00, 1'b1, 1'b0);
      cyc(8'h00, 8'h00, 1'b1, 1'b0);
    end
    chk("missed_sat", missed_cnt, EDGE ? 8'd255 : 8'd0);
    chk("miss_hold_vec", 8'(vec), 8'h04);
    cyc(8'h00, 8'h00, 1'b1, 1'b1);
    cyc(8'h00, 8'h00, 1'b1, 1'b1);
    cyc(8'h00, 8'h00, 1'b1, 1'b1);
    chk("miss_drain_valid", 8'(vec_valid), 8'h00);
    chk("miss_drain_enc_i", enc_i, 8'h00);

    // ---- asynchronous reset during an offer ----
    cyc(8'h01, 8'h00, 1'b1, 1'b0);
    k = 0;
    while (!vec_valid && k < 6) begin cyc(8'h00, 8'h00, 1'b1, 1'b0); k++; end
    chk("rstoff_valid_pre", 8'(vec_valid), 8'h01);
    #3 rst = 1'b1;
    #1;
    chk("rstoff_valid", 8'(vec_valid), 8'h00);
    chk("rstoff_enc_i", enc_i, 8'h00);
    chk("rstoff_vec", 8'(vec), 8'h00);
    chk("rstoff_missed", missed_cnt, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      cyc(8'h00, 8'h00, 1'b1, 1'b1);
      chk($sformatf("postrst%0d_valid", j), 8'(vec_valid), 8'h00);
    end

    // ---- randomized run against the model ----
    do_reset();
    model_reset();
    for (int j = 0; j < 800; j++) begin
      logic [7:0] ri, rm;
      logic re, rr;
      ri = ($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom) : 8'h00;
      rm = ($urandom_range(0, 15) == 0) ? 8'($urandom & $urandom) : mask;
      re = ($urandom_range(0, 7) != 0);
      rr = ($urandom_range(0, 2) != 0);
      model_step(ri, rm, re, rr);
      cyc(ri, rm, re, rr);
      chk("rnd_valid", 8'(vec_valid), 8'(m_valid));
      if (m_valid) chk("rnd_vec", 8'(vec), 8'(m_vec));
      chk("rnd_enc_i", enc_i, m_pend & ~rm);
      chk("rnd_missed", missed_cnt, m_miss);
      chk("rnd_idle_empty", 8'(idle_empty), 8'(m_ie));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/irq_pending_ctrl.md
# irq_pending_ctrl

Interrupt pending/acknowledge controller for eight request lines. It edge-detects and latches requests into a pending register and applies a per-line mask. The masked pending vector drives the adjacent 8-to-3 priority encoder, and the controller registers the encoder's result as a vector offered to the consumer over a valid/ready handshake. On acknowledge it clears the serviced pending bit. It is the stage that feeds the priority encoder's I/EI inputs and consumes its Y/GS/EO outputs.

## Interface
- No parameters; width fixed at 8 request lines / 3-bit vector.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- irq  input  8  request lines, synchronous to clk
- mask  input  8  1 = line masked (still latched as pending, never offered)
- enable  input  1  global arbitration enable
- enc_i  output  8  to encoder I: pending & ~mask (combinational from registers)
- enc_ei  output  1  to encoder EI: enable & (state == IDLE)
- enc_y  input  3  from encoder Y
- enc_gs  input  1  from encoder GS
- enc_eo  input  1  from encoder EO (used only for the idle_empty status)
- vec_valid  output  1  vector offer valid
- vec  output  3  offered vector, highest unmasked pending index
- vec_ready  input  1  consumer accepts vec when high with vec_valid
- idle_empty  output  1  registered: state == IDLE and enc_eo was high last cycle
- missed_cnt  output  8  saturating count of requests lost because the line was already pending

## Operation
- irq_q: registered copy of irq.
- rise = irq & ~irq_q (edge mode).
- Pending update each edge: pending <= (pending & ~clr) | set.
  - set = rise.
  - clr = onehot(vec) on a handshake, else 0.
  - If set and clr hit the same bit in the same cycle, set wins and the bit stays pending.
- missed_cnt increments by 1 for any cycle where (set & pending & ~clr) != 0. It increments by at most 1 per cycle and saturates at 255.
- FSM states: IDLE, OFFER, GAP.
  - IDLE: if enc_gs is high, then vec <= enc_y, vec_valid <= 1, go to OFFER.
  - OFFER: hold vec and vec_valid. On vec_valid & vec_ready, clear pending[vec], vec_valid <= 0, go to GAP.
  - GAP: one cycle, then go to IDLE. This lets the cleared pending bit propagate through the encoder before the next capture.
- Dropping enable or changing mask during OFFER does not retract the offer; the vector completes its handshake.
- Masked pending bits stay pending and are offered once unmasked.
- Reset, whether asynchronous or mid-offer, forces state = IDLE, pending = 0, irq_q = 0, vec = 0, vec_valid = 0, missed_cnt = 0, idle_empty = 0. Any offer in progress is discarded with no clear.

## Timing
- Latency: irq first high before edge k → pending bit set at edge k → vec_valid high after edge k+1.
- enc_i and enc_ei are combinational from registers; the encoder path is combinational; the IDLE capture is registered.
- Handshake accepted on any edge with vec_valid & vec_ready. vec_ready may be held high permanently.
- Minimum spacing between successive offers is 3 cycles: OFFER (1 cycle with ready) → GAP → IDLE capture → next OFFER.
- vec is stable from vec_valid rising until the accepting edge.
- idle_empty lags enc_eo by one cycle.

## Configuration
- IRQ_EDGE_DETECT_EN defined: set = irq & ~irq_q, i.e. edge-triggered requests as described above.
- IRQ_EDGE_DETECT_EN undefined: set = irq_q, i.e. level-sensitive requests.
  - A line held high re-pends in the cycle after its clear; set wins, so it effectively stays pending.
  - missed_cnt is tied to 0.
  - All other behaviour is unchanged.

## Test plan
- Reset then idle, enable = 1, no irq → vec_valid = 0, enc_i = 0x00, idle_empty = 1 from the second cycle, missed_cnt = 0.
- Pulse irq = 0x24 for one cycle, vec_ready = 1:
  - vec = 5 offered 2 cycles after the pulse and accepted; pending = 0x04.
  - vec = 2 offered 3 cycles later; pending ends at 0x00.
- mask = 0x80, pulse irq[7] and irq[1]:
  - vec = 1 is offered; pending[7] remains.
  - Clear the mask → vec = 7 is offered.
- Hold vec_ready = 0 for 10 cycles during the offer of vec = 3 while toggling enable and pulsing irq[6] → vec stays 3, vec_valid stays high. After ready, vec = 6 is offered next.
- Pulse irq[4] three times while pending[4] = 1 and the handshake is stalled → missed_cnt = 3 (edge build). Repeat until the count saturates at 255.
- Assert rst mid-OFFER → vec_valid drops immediately (asynchronous), and pending = 0. After release, no offer is made until a new irq.
